// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: datapath width, requester-tag
// width helper and the round-robin one-hot pick used by the arbiter.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;

    // Round-robin search vector is sized for the largest legal requester count.
    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_IDX_W = 3;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of vec at or after ptr, wrapping n-1 -> 0; one-hot result.
    function automatic logic [RR_MAX-1:0] rr_onehot(
        input logic [RR_MAX-1:0]   vec,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         n
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = (32'(ptr) + k) % n;
                if (!found && vec[idx[RR_IDX_W-1:0]]) begin
                    grant[idx[RR_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit two-level carry-lookahead adder, no carry-in.
// Ports: a_i, b_i operands; sum_c_o = a+b mod 2^32; c32_c_o carry out of bit 31.
module adder32
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] a_i,
    input  logic [ALU_DATA_W-1:0] b_i,
    output logic [ALU_DATA_W-1:0] sum_c_o,
    output logic                  c32_c_o
);

    localparam int unsigned GRP_W = 4;
    localparam int unsigned N_GRP = ALU_DATA_W / GRP_W;

    logic [ALU_DATA_W-1:0] g;
    logic [ALU_DATA_W-1:0] p;
    logic [ALU_DATA_W:0]   c;
    logic [N_GRP-1:0]      gg;
    logic [N_GRP-1:0]      pg;
    logic [N_GRP:0]        cg;

    // First level: bit generate/propagate folded into 4-bit group G/P.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        pg = '0;
        for (int unsigned k = 0; k < N_GRP; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
    end

    // Second level: group carries, then bit carries inside each group.
    always_comb begin
        cg    = '0;
        cg[0] = 1'b0;
        for (int unsigned k = 0; k < N_GRP; k++) begin
            cg[k+1] = gg[k] | (pg[k] & cg[k]);
        end
        c = '0;
        for (int unsigned k = 0; k < N_GRP; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        c[ALU_DATA_W] = cg[N_GRP];
    end

    assign sum_c_o = p ^ c[ALU_DATA_W-1:0];
    assign c32_c_o = c[ALU_DATA_W];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
// Ports: req_i request vector; ptr_i highest-priority index;
//        grant_c_o one-hot grant; idx_c_o encoded index of the grant.
module rr_pick
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_c_o,
    output logic [ID_W-1:0] idx_c_o
);

    logic [RR_MAX-1:0] grant_full;

    // Pick on the padded vector, then encode; encoder spans the full vector.
    always_comb begin
        grant_full = rr_onehot(RR_MAX'(req_i), RR_IDX_W'(ptr_i), NREQ);
        grant_c_o  = grant_full[NREQ-1:0];
        idx_c_o    = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (grant_full[i]) begin
                idx_c_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder32 among NREQ requesters through a round-robin arbiter and a
// two-stage pipeline (operand register -> result register).
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b per-requester handshake
//        (requester i at bit i / slice [32*i +: 32]); rsp_valid/rsp_ready
//        tagged response with rsp_id, rsp_sum, rsp_carry; busy = pipeline
//        holds any transaction.
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ID_W   = id_width(NREQ),
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_carry,
    output logic                   busy
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]   grant_c;
    logic [ID_W-1:0]   grant_idx_c;
    logic              s2_load_c;
    logic              s1_free_c;
    logic              accept_c;
    logic [DATA_W-1:0] pick_a_c;
    logic [DATA_W-1:0] pick_b_c;
    logic [DATA_W-1:0] add_sum_c;
    logic              add_carry_c;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_c_o (grant_c),
        .idx_c_o   (grant_idx_c)
    );

    adder32 u_adder32 (
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .sum_c_o (add_sum_c),
        .c32_c_o (add_carry_c)
    );

    // Handshake: stage 1 may take a new operand pair when empty or draining.
    // req_ready is forced low while reset is asserted.
    always_comb begin
        s2_load_c = s1_valid_q & (~rsp_valid_q | rsp_ready);
        s1_free_c = ~s1_valid_q | s2_load_c;
        req_ready = rst_n ? (grant_c & {NREQ{s1_free_c}}) : '0;
        accept_c  = |(req_valid & req_ready);
    end

    // One-hot operand mux driven by the grant.
    always_comb begin
        pick_a_c = '0;
        pick_b_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                pick_a_c = req_a[i*DATA_W +: DATA_W];
                pick_b_c = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (s2_load_c) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum_c;
            rsp_carry_d = add_carry_c;
            rsp_id_d    = s1_id_q;
            s1_valid_d  = 1'b0;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // A same-cycle refill overrides the drain of stage 1.
        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_a_d     = pick_a_c;
            s1_b_d     = pick_b_c;
            s1_id_d    = grant_idx_c;
            rr_ptr_d   = (grant_idx_c == ID_W'(NREQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
        end
    end

    // Pipeline and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, hand-written
// multi-cycle sequences and a scoreboard monitor with a random soak.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int DW   = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [DW-1:0]        rsp_sum;
    logic                 rsp_carry;
    logic                 busy;

    adder_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    int          n_tests;
    int          n_fail;
    txn_t        q[$];
    logic [NREQ-1:0] acc_v;
    int          waits[NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: records accepts, checks responses and fairness.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_v = '0;
            for (int i = 0; i < NREQ; i++) waits[i] = 0;
        end else begin
            acc_v = req_valid & req_ready;
            if (acc_v != '0) begin
                chk("grant_onehot", 64'($countones(acc_v)), 64'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (acc_v[i]) begin
                        txn_t t;
                        t.id = i;
                        t.a  = req_a[i*DW +: DW];
                        t.b  = req_b[i*DW +: DW];
                        q.push_back(t);
                        chk("fair_wait", 64'(waits[i] < NREQ), 64'd1);
                        waits[i] = 0;
                    end else if (req_valid[i]) begin
                        waits[i]++;
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) waits[i] = 0;
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: got response id %0d with nothing outstanding", rsp_id);
                end else begin
                    txn_t t;
                    logic [32:0] full;
                    t    = q.pop_front();
                    full = {1'b0, t.a} + {1'b0, t.b};
                    chk("sb_id", 64'(rsp_id), 64'(t.id));
                    chk("sb_sum", 64'(rsp_sum), 64'(full[31:0]));
                    chk("sb_carry", 64'(rsp_carry), 64'(full[32]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        logic [31:0] cap_sum;
        logic [ID_W-1:0] cap_id;
        logic cap_carry;
        int acc_cnt;

        n_tests = 0;
        n_fail  = 0;
        vt[0] = '{2, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vt[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vt[2] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vt[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vt[4] = '{2, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
        vt[5] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[6] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        // Reset state, with all requesters asserting to exercise the gating.
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed single-request vectors.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk);
            #1;
            req_valid = NREQ'(1) << vt[v].id;
            set_op(vt[v].id, vt[v].a, vt[v].b);
            @(negedge clk);
            chk("vec_req_ready", 64'(req_ready), 64'(NREQ'(1) << vt[v].id));
            @(posedge clk);
            #1;
            req_valid = '0;
            @(negedge clk);
            chk("vec_s1_busy", 64'({busy, rsp_valid}), 64'b10);
            @(negedge clk);
            chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("vec_rsp_sum", 64'(rsp_sum), 64'(vt[v].sum));
            chk("vec_rsp_carry", 64'(rsp_carry), 64'(vt[v].carry));
            chk("vec_rsp_id", 64'(rsp_id), 64'(vt[v].id));
            @(negedge clk);
            chk("vec_idle", 64'({busy, rsp_valid}), 64'b00);
        end

        // Round-robin with all requesters held high.
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h1111_1111 * (i + 1), 32'hF000_0000 + i);
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(NREQ'(1) << (k % NREQ)));
            if (k >= 2) begin
                chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
                chk("rr_rsp_id", 64'(rsp_id), 64'((k - 2) % NREQ));
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Backpressure: two requesters, output stalled for five cycles.
        apply_reset();
        rsp_ready = 1'b0;
        set_op(1, 32'h0000_1000, 32'h0000_0234);
        set_op(3, 32'hFFFF_FFF0, 32'h0000_0020);
        req_valid = 4'b1010;
        acc_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc_cnt += $countones(req_valid & req_ready);
            if (k == 2) begin
                cap_sum   = rsp_sum;
                cap_id    = rsp_id;
                cap_carry = rsp_carry;
                chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            end
            if (k >= 2) begin
                chk("bp_no_ready", 64'(req_ready), 64'd0);
                chk("bp_stable_sum", 64'(rsp_sum), 64'(cap_sum));
                chk("bp_stable_id", 64'(rsp_id), 64'(cap_id));
                chk("bp_stable_carry", 64'(rsp_carry), 64'(cap_carry));
                chk("bp_stable_valid", 64'(rsp_valid), 64'd1);
            end
        end
        chk("bp_accepts", 64'(acc_cnt), 64'd2);
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain0_id", 64'(rsp_id), 64'd1);
        chk("bp_drain0_sum", 64'(rsp_sum), 64'h0000_1234);
        @(negedge clk);
        chk("bp_drain1_id", 64'(rsp_id), 64'd3);
        chk("bp_drain1_sum", 64'(rsp_sum), 64'h0000_0010);
        chk("bp_drain1_carry", 64'(rsp_carry), 64'd1);
        @(negedge clk);
        chk("bp_drained", 64'({rsp_valid, busy}), 64'b00);
        chk("bp_sb_empty", 64'(q.size()), 64'd0);

        // Reset while both stages hold data.
        apply_reset();
        rsp_ready = 1'b0;
        set_op(0, 32'd10, 32'd20);
        set_op(1, 32'd30, 32'd40);
        set_op(2, 32'd50, 32'd60);
        req_valid = 4'b0011;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("mr_full", 64'({busy, rsp_valid}), 64'b11);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b0110;
        q.delete();
        #1;
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mr_first_grant", 64'(req_ready), 64'b0010);
        chk("mr_no_stale_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // Random soak: requests held until accepted, random output stalls.
        apply_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc_v[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_op(i, rand_op(), rand_op());
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("soak_sb_empty", 64'(q.size()), 64'd0);
        chk("soak_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one adder32 instance (32-bit, two-level carry-lookahead, no carry-in) among NREQ independent requesters.
- Round-robin arbitration, a registered operand stage and a registered result stage give a 2-stage pipeline.
- Valid/ready handshakes on every requester port and on the single tagged response port.
- Sits between the ALU front-end clients and the adder datapath, as the adder's sole owner.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- ID_W, $clog2(NREQ), width of the requester tag.
- DATA_W, 32, operand width; fixed by adder32, any other value is illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i = requester i presents operands.
- req_ready  out  NREQ  bit i = requester i accepted this cycle.
- req_a  in  NREQ*32  operand A; requester i at [32*i+31:32*i].
- req_b  in  NREQ*32  operand B; same packing as req_a.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  32  A+B mod 2^32.
- rsp_carry  out  1  carry out of bit 31 (adder32 C32).
- busy  out  1  s1_valid | rsp_valid.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0.
  - rr_ptr=0; req_ready=0 while rst_n=0.
- Stage 1 (operand register): s1_valid, s1_a, s1_b, s1_id. Stage 2 (result register): rsp_valid, rsp_sum, rsp_carry, rsp_id.
- adder32 inputs are driven from s1_a and s1_b. Sum and carry are combinational and are captured into stage 2.
- s2_load = s1_valid & (!rsp_valid | rsp_ready).
- s1_free = !s1_valid | s2_load.
- Grant: combinational, one-hot. Pick the first asserted req_valid bit searching from rr_ptr upward, with wrap NREQ-1 -> 0.
- req_ready[i] = grant[i] & s1_free. At most one bit is high. It never depends on req_valid[j] for j != i beyond the priority search.
- Accept (req_valid[i] & req_ready[i]):
  - load s1 with that requester's operands and s1_id=i, set s1_valid=1;
  - rr_ptr <= (i+1) mod NREQ.
- rr_ptr is unchanged on cycles with no accept.
- Stage-2 register rules:
  - On s2_load: capture sum, carry and s1_id; set rsp_valid=1.
  - If s1 does not refill in the same cycle, s1_valid <= 0.
  - If rsp_valid & rsp_ready & !s2_load: rsp_valid <= 0.
  - If rsp_valid & !rsp_ready: hold all rsp_* stable. s1 holds. No new accept if s1_valid.
- Latency: accept in cycle T gives rsp_valid in T+1 when the output is unstalled. Throughput is 1 result per cycle.
- Simultaneous accept, s2_load and rsp handshake in one cycle is legal. All three advance together with no bubble.
- Requesters must hold operands stable while req_valid=1 and req_ready=0. The block samples them only on accept.
- Fairness: a continuously requesting requester is granted within NREQ accepts.
- Arithmetic: unsigned 32-bit sum; rsp_carry = (A+B)>>32. Wrap-around is reported through the carry only, with no saturation.
- Reset mid-operation clears both stages. In-flight results are dropped and no response is issued for them.

Decomposition:
- Shared package alu_pkg:
  - constant ALU_DATA_W=32;
  - function for the round-robin one-hot pick (vector, pointer) -> one-hot grant;
  - ID width helper.
- One sub-module rr_pick: combinational round-robin priority selector (NREQ, req vector, pointer -> one-hot grant, encoded index). The pipeline and handshake logic stay in adder_arbiter.
- adder32 is instantiated unchanged.

Test Plan:
- Single request: requester 2, A=0x0000_0005, B=0x0000_0007, rsp_ready=1 -> rsp_valid one cycle after accept; rsp_sum=0x0000_000C, rsp_carry=0, rsp_id=2.
- Overflow: A=0xFFFF_FFFF, B=0x0000_0001 -> rsp_sum=0x0000_0000, rsp_carry=1. Also A=0x8000_0000, B=0x8000_0000 -> rsp_sum=0, rsp_carry=1.
- Round-robin: all 4 req_valid held high with distinct operands, rsp_ready=1 -> accepted ids 0,1,2,3,0,1,... One result per cycle in the same order with matching sums.
- Backpressure: rsp_ready=0 for 5 cycles with 2 requesters active:
  - exactly 2 accepts, then req_ready=0 for all;
  - rsp_* stable throughout;
  - on rsp_ready=1, both results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 while s1 and s2 hold data:
  - rsp_valid=0 and busy=0 immediately (async);
  - after release, the first grant goes to the lowest-index requesting port (rr_ptr=0).
- Random soak: 10k cycles of random req_valid, operands and rsp_ready -> every accepted transaction yields exactly one response with the correct sum, carry and id. Per-requester order is preserved. No requester waits more than NREQ grants.
